// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared element codes, sprite sizes and fetch FSM states
package sprite_pkg;

    localparam int ELEM_W = 3;

    localparam logic [ELEM_W-1:0] ELEM_FRUIT      = 3'd1;
    localparam logic [ELEM_W-1:0] ELEM_HEART      = 3'd2;
    localparam logic [ELEM_W-1:0] ELEM_SNAKE      = 3'd3;
    localparam logic [ELEM_W-1:0] ELEM_BACKGROUND = 3'd4;
    localparam logic [ELEM_W-1:0] ELEM_BLOCK      = 3'd5;

    localparam logic [11:0] TRANSPARENT_COLOUR = 12'hF0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } fetch_state_t;

    // Square sprite edge length in pixels; 0 marks codes that never draw.
    function automatic logic [6:0] elem_size(input logic [ELEM_W-1:0] code);
        case (code)
            ELEM_FRUIT:      return 7'd25;
            ELEM_HEART:      return 7'd16;
            ELEM_SNAKE:      return 7'd20;
            ELEM_BACKGROUND: return 7'd100;
            ELEM_BLOCK:      return 7'd25;
            default:         return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// rtl/sprite_hit_test.sv - coverage test and in-sprite address for one slot
module sprite_hit_test
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic [ELEM_W-1:0] elem,
    input  logic              active,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    logic [10:0] size;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0]  dx;
    logic [9:0]  dy;

    // 11-bit compares so a sprite hanging off the right/bottom edge does not wrap
    always_comb begin
        size  = {4'd0, elem_size(elem)};
        x_end = {1'b0, sx} + size;
        y_end = {1'b0, sy} + size;
        hit   = active && (size != 11'd0)
             && ({1'b0, px} >= {1'b0, sx}) && ({1'b0, px} < x_end)
             && ({1'b0, py} >= {1'b0, sy}) && ({1'b0, py} < y_end);
        dx    = px - sx;
        dy    = py - sy;
        addr  = ADDR_W'(21'(dy) * 21'(size) + 21'(dx));
    end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// rtl/sprite_pixel_fetch.sv - priority sprite scan and colour fetch; option SPRITE_TRANSPARENT_KEY_EN
module sprite_pixel_fetch #(
    parameter int          SLOTS     = 8,
    parameter int          ELEM_W    = sprite_pkg::ELEM_W,
    parameter int          ADDR_W    = 14,
    parameter int          RD_LAT    = 1,
    parameter logic [11:0] BG_COLOUR = 12'h000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pixel_req,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic                       slot_we,
    input  logic [$clog2(SLOTS)-1:0]   slot_idx,
    input  logic [9:0]                 slot_x,
    input  logic [9:0]                 slot_y,
    input  logic [ELEM_W-1:0]          slot_elem,
    input  logic                       slot_active,
    output logic                       read_enable,
    output logic [ELEM_W-1:0]          element,
    output logic [ADDR_W-1:0]          address_sprite,
    input  logic [11:0]                mem_data,
    output logic                       pixel_valid,
    output logic [11:0]                pixel_colour,
    output logic                       busy,
    output logic                       overrun
);

    import sprite_pkg::*;

    localparam int                IDX_W = $clog2(SLOTS);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(SLOTS - 1);

    logic [9:0]        tbl_x      [SLOTS];
    logic [9:0]        tbl_y      [SLOTS];
    logic [ELEM_W-1:0] tbl_elem   [SLOTS];
    logic [SLOTS-1:0]  tbl_active;

    fetch_state_t      state;
    logic [IDX_W-1:0]  idx;
    logic [9:0]        px;
    logic [9:0]        py;
    logic [2:0]        cnt;
    logic              hit;
    logic [ADDR_W-1:0] hit_addr;

    // Slot geometry and element code; only the active flags need a reset value
    always_ff @(posedge clk) begin
        if (slot_we) begin
            tbl_x[slot_idx]    <= slot_x;
            tbl_y[slot_idx]    <= slot_y;
            tbl_elem[slot_idx] <= slot_elem;
        end
    end

    // Active flags, cleared by reset so an unprogrammed table never hits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbl_active <= '0;
        end else if (slot_we) begin
            tbl_active[slot_idx] <= slot_active;
        end
    end

    sprite_hit_test #(.ADDR_W(ADDR_W)) u_hit_test (
        .px     (px),
        .py     (py),
        .sx     (tbl_x[idx]),
        .sy     (tbl_y[idx]),
        .elem   (tbl_elem[idx]),
        .active (tbl_active[idx]),
        .hit    (hit),
        .addr   (hit_addr)
    );

    // Fetch sequencer; every output is set on the transition into its state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            px             <= '0;
            py             <= '0;
            cnt            <= '0;
            read_enable    <= 1'b0;
            element        <= '0;
            address_sprite <= '0;
            pixel_valid    <= 1'b0;
            pixel_colour   <= '0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            read_enable <= 1'b0;
            pixel_valid <= 1'b0;
            if (pixel_req && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pixel_req) begin
                        px    <= pixel_x;
                        py    <= pixel_y;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        element        <= tbl_elem[idx];
                        address_sprite <= hit_addr;
                        read_enable    <= 1'b1;
                        state          <= ST_ISSUE;
                    end else if (idx == LAST) begin
                        pixel_colour <= BG_COLOUR;
                        pixel_valid  <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= 3'(RD_LAT);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 3'd1) begin
`ifdef SPRITE_TRANSPARENT_KEY_EN
                        if (mem_data == TRANSPARENT_COLOUR) begin
                            if (idx != LAST) begin
                                idx   <= idx + 1'b1;
                                state <= ST_SCAN;
                            end else begin
                                pixel_colour <= BG_COLOUR;
                                pixel_valid  <= 1'b1;
                                state        <= ST_DONE;
                            end
                        end else begin
                            pixel_colour <= mem_data;
                            pixel_valid  <= 1'b1;
                            state        <= ST_DONE;
                        end
`else
                        pixel_colour <= mem_data;
                        pixel_valid  <= 1'b1;
                        state        <= ST_DONE;
`endif
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// tb/tb_sprite_pixel_fetch.sv - randomized bench for sprite_pixel_fetch against a slot-table model
module tb_sprite_pixel_fetch;

    localparam int          SLOTS  = 8;
    localparam int          ELEM_W = 3;
    localparam int          ADDR_W = 14;
    localparam int          RD_LAT = 1;
    localparam logic [11:0] BG     = 12'h000;

    logic              clk;
    logic              reset;
    logic              pixel_req;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              slot_we;
    logic [2:0]        slot_idx;
    logic [9:0]        slot_x;
    logic [9:0]        slot_y;
    logic [ELEM_W-1:0] slot_elem;
    logic              slot_active;
    logic              read_enable;
    logic [ELEM_W-1:0] element;
    logic [ADDR_W-1:0] address_sprite;
    logic [11:0]       mem_data;
    logic              pixel_valid;
    logic [11:0]       pixel_colour;
    logic              busy;
    logic              overrun;

    sprite_pixel_fetch #(
        .SLOTS(SLOTS), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BG_COLOUR(BG)
    ) dut (
        .clk(clk), .reset(reset), .pixel_req(pixel_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .slot_we(slot_we), .slot_idx(slot_idx), .slot_x(slot_x), .slot_y(slot_y),
        .slot_elem(slot_elem), .slot_active(slot_active), .read_enable(read_enable),
        .element(element), .address_sprite(address_sprite), .mem_data(mem_data),
        .pixel_valid(pixel_valid), .pixel_colour(pixel_colour), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference slot table and sprite sizes by element code
    int  m_x    [SLOTS];
    int  m_y    [SLOTS];
    int  m_elem [SLOTS];
    bit  m_act  [SLOTS];
    int  size_tab [8] = '{0, 25, 16, 20, 100, 25, 0, 0};

    // memory bank model: per-element override, otherwise a hash of element/address
    bit          ovr_en  [8];
    logic [11:0] ovr_val [8];

    function automatic logic [11:0] mem_colour(input int e, input int a);
        if (ovr_en[e]) return ovr_val[e];
        return 12'((e * 331) + (a * 7) + 165);
    endfunction

    logic [11:0] mem_pipe [RD_LAT];

    always @(posedge clk) begin
        mem_pipe[0] <= read_enable ? mem_colour(int'(element), int'(address_sprite)) : 12'hEEE;
        for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign mem_data = mem_pipe[RD_LAT-1];

    task automatic write_slot(input int s, input int x, input int y, input int e, input bit a);
        @(negedge clk);
        slot_we     = 1'b1;
        slot_idx    = 3'(s);
        slot_x      = 10'(x);
        slot_y      = 10'(y);
        slot_elem   = 3'(e);
        slot_active = a;
        @(negedge clk);
        slot_we = 1'b0;
        m_x[s] = x; m_y[s] = y; m_elem[s] = e; m_act[s] = a;
    endtask

    // Walk the slots in priority order; cost is one cycle per slot examined,
    // 1+RD_LAT per read issued, and one more for the valid pulse.
    task automatic predict(input int x, input int y, output int lat, output int reads,
                           output int e0, output int a0, output logic [11:0] col);
        int scans;
        int sz;
        int a;
        logic [11:0] c;
        scans = 0; reads = 0; e0 = 0; a0 = 0; col = BG;
        for (int s = 0; s < SLOTS; s++) begin
            scans++;
            sz = size_tab[m_elem[s]];
            if (m_act[s] && sz != 0 && x >= m_x[s] && x < m_x[s] + sz
                && y >= m_y[s] && y < m_y[s] + sz) begin
                a = (y - m_y[s]) * sz + (x - m_x[s]);
                c = mem_colour(m_elem[s], a);
                if (reads == 0) begin e0 = m_elem[s]; a0 = a; end
                reads++;
`ifdef SPRITE_TRANSPARENT_KEY_EN
                if (c == 12'hF0F) continue;
`endif
                col = c;
                break;
            end
        end
        lat = scans + reads * (1 + RD_LAT) + 1;
    endtask

    task automatic run_pixel(input int x, input int y, input int poke_at);
        int lat, reads, e0, a0;
        logic [11:0] col;
        int got_reads, got_e, got_a, got_lat;
        logic [11:0] got_col;
        bit done;
        predict(x, y, lat, reads, e0, a0, col);
        got_reads = 0; got_e = -1; got_a = -1; got_lat = -1; got_col = 12'h000; done = 0;
        @(negedge clk);
        pixel_req = 1'b1;
        pixel_x   = 10'(x);
        pixel_y   = 10'(y);
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge clk);
            pixel_req = (n == poke_at);
            if (read_enable) begin
                if (got_reads == 0) begin got_e = int'(element); got_a = int'(address_sprite); end
                got_reads++;
            end
            if (pixel_valid) begin
                got_lat = n; got_col = pixel_colour; done = 1;
            end
        end
        pixel_req = 1'b0;
        check("latency", got_lat, lat);
        check("reads", got_reads, reads);
        if (reads > 0) begin
            check("element", got_e, e0);
            check("address", got_a, a0);
        end
        check("colour", got_col, col);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; pixel_req = 1'b0; pixel_x = '0; pixel_y = '0;
        slot_we = 1'b0; slot_idx = '0; slot_x = '0; slot_y = '0; slot_elem = '0; slot_active = 1'b0;
        for (int i = 0; i < 8; i++) begin ovr_en[i] = 0; ovr_val[i] = '0; end
        for (int s = 0; s < SLOTS; s++) begin m_x[s] = 0; m_y[s] = 0; m_elem[s] = 0; m_act[s] = 0; end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_read_enable", read_enable, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_colour", pixel_colour, 0);
        check("rst_element", element, 0);
        check("rst_address", address_sprite, 0);
        reset = 1'b1;
        @(negedge clk);

        // single hit on slot 0
        ovr_en[2] = 1; ovr_val[2] = 12'hABC;
        write_slot(0, 100, 50, 2, 1);
        run_pixel(110, 60, 0);
        ovr_en[2] = 0;

        // empty table
        write_slot(0, 100, 50, 2, 0);
        run_pixel(0, 0, 0);

        // right-edge boundary on slot 3
        write_slot(3, 200, 200, 1, 1);
        run_pixel(224, 224, 0);
        run_pixel(225, 224, 0);
        run_pixel(200, 200, 0);
        run_pixel(199, 210, 0);

        // priority between overlapping slots, plus a request during WAIT
        write_slot(1, 300, 300, 4, 1);
        write_slot(5, 310, 310, 2, 1);
        check("overrun_before", overrun, 0);
        run_pixel(315, 315, 4);
        check("overrun_sticky", overrun, 1);
        repeat (3) @(negedge clk);
        check("ignored_req_idle", busy, 0);

        // randomized tables and pixels
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < SLOTS; s++)
                write_slot(s, $urandom_range(100, 180), $urandom_range(100, 180),
                           $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            for (int p = 0; p < 8; p++)
                run_pixel($urandom_range(90, 300), $urandom_range(90, 300), 0);
        end

        // reset during WAIT
        for (int s = 0; s < SLOTS; s++) write_slot(s, 0, 0, 0, 0);
        write_slot(0, 100, 50, 2, 1);
        @(negedge clk);
        pixel_req = 1'b1; pixel_x = 10'd110; pixel_y = 10'd60;
        @(negedge clk);
        pixel_req = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_in_wait", busy, 1);
        reset = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_read_enable", read_enable, 0);
        check("async_pixel_valid", pixel_valid, 0);
        check("async_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < SLOTS; s++) m_act[s] = 0;
        run_pixel(110, 60, 0);

`ifdef SPRITE_TRANSPARENT_KEY_EN
        // transparent colour on slot 0 falls through to slot 2
        ovr_en[3] = 1; ovr_val[3] = 12'hF0F;
        ovr_en[5] = 1; ovr_val[5] = 12'h123;
        write_slot(0, 400, 400, 3, 1);
        write_slot(2, 400, 400, 5, 1);
        run_pixel(405, 405, 0);
        write_slot(2, 400, 400, 5, 0);
        run_pixel(405, 405, 0);
        ovr_en[3] = 0; ovr_en[5] = 0;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
